glitch_pulse_gen: RTL and testbench
===================================

Name: glitch_pulse_gen

Overview:
- Sits directly downstream of the trigger delay stage; consumes its `delayed_trigger` output as `trig_in`.
- On a rising edge of `trig_in` while armed, emits a burst of `count` glitch pulses on `glitch_out`. Each pulse is `width` clk cycles high, separated by `gap` clk cycles low.
- Feeds the glitch driver (crowbar/clock-mux select). Supports one-shot and auto-rearm modes, plus an immediate abort.

Parameters:
- CNT_W, 16, width of the `width` and `gap` counters.
- NUM_W, 8, width of the pulse-count field.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous assert, active-low
- trig_in  in  1  delayed trigger; asynchronous to clk (target-clock domain)
- width  in  CNT_W  pulse high time in clk cycles
- gap  in  CNT_W  low time between pulses in clk cycles
- count  in  NUM_W  pulses per burst
- rearm  in  1  auto-rearm after a burst (1) or one-shot (0)
- set_cfg  in  1  one-cycle strobe; latch width/gap/count/rearm
- arm  in  1  one-cycle strobe; DISARMED -> ARMED
- abort  in  1  one-cycle strobe; force DISARMED
- glitch_out  out  1  registered glitch drive
- armed  out  1  high in ARMED
- busy  out  1  high in PULSE or GAP
- done  out  1  one-cycle strobe at burst completion

Behaviour:
- Reset values: glitch_out=0, armed=0, busy=0, done=0, state=DISARMED, config registers=0, synchronizer flops=0.
- Input synchronization: trig_in passes through a 2-flop synchronizer, then an edge register. `trig_rise` = s2 & ~s3.
- Latency: if trig_in is sampled high at posedge N (previous sample low), glitch_out goes high after posedge N+3.
- Config latch:
  - set_cfg is accepted only in DISARMED or ARMED; it is ignored in PULSE, GAP and HOLDOFF.
  - width=0 behaves as 1; gap=0 behaves as 1; count=0 behaves as 1.
- States:
  - DISARMED: glitch_out=0. On arm -> ARMED.
  - ARMED: armed=1. On trig_rise -> PULSE; load width counter; load pulse counter with count.
  - PULSE: glitch_out=1 for exactly eff_width cycles.
    - At end of pulse, if pulses remain -> GAP.
    - At end of the last pulse -> HOLDOFF; glitch_out drops and done=1 in the same cycle.
  - GAP: glitch_out=0 for exactly eff_gap cycles, then -> PULSE.
  - HOLDOFF: wait for synchronized trig low (s2=0). Then -> ARMED if latched rearm=1, else -> DISARMED.
- Abort: from any state -> DISARMED; glitch_out=0 after the next posedge.
  - abort and arm in the same cycle: abort wins.
  - done is not asserted on abort.
- arm outside DISARMED is ignored.
- A trig_rise outside ARMED is ignored; it is not queued.
- Counters are down-counters of CNT_W / NUM_W bits. No wrap-around is possible, since loading happens only at state entry. A maximum value of all-ones is legal.
- Asynchronous reset mid-burst: glitch_out drops immediately (asynchronous clear) and no done is issued.

Optional Feature:
- Macro GLITCH_STATS_EN.
- Defined: adds output `fire_count` [15:0]. It increments on each done, saturates at 16'hFFFF, is cleared only by rst_n, and is unaffected by abort.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package `glitch_pkg`:
  - state enum `glitch_state_t` {DISARMED, ARMED, PULSE, GAP, HOLDOFF}
  - constants DEF_CNT_W=16, DEF_NUM_W=8
- Sub-module `sync_edge_detect`: 2-flop synchronizer plus rising-edge register. It has an active-low async reset and outputs the synchronized level and a rise strobe. It is reusable for other asynchronous inputs.

Test Plan:
- Burst: set_cfg with width=3, gap=2, count=2, rearm=0; arm; trig_in rises at posedge 10 -> glitch_out high 13–15, low 16–17, high 18–20; done at 21; state DISARMED after trig_in falls.
- Zero config: width=0, gap=0, count=0; arm; trigger -> single 1-cycle pulse; done asserted.
- Rearm: rearm=1, count=1, width=1; two trig_in pulses -> two pulses and two done strobes. A trig_in edge during HOLDOFF is ignored; armed returns only after trig_in goes low.
- Abort: abort during the 2nd PULSE of a count=4 burst -> glitch_out 0 next cycle; no done; armed=0. Simultaneous arm+abort -> stays DISARMED.
- Config while busy: set_cfg with width=9 issued mid-burst -> current burst keeps the old width; the next burst, after arm, also keeps the old width because the mid-burst set_cfg was ignored.
- With GLITCH_STATS_EN: 3 bursts -> fire_count=3. Preload via force to 16'hFFFF plus one burst -> stays 16'hFFFF.

Source files
------------

// File: rtl/glitch_pkg.sv
// Shared types and default widths for the glitch pulse generator.
package glitch_pkg;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_NUM_W = 8;

    typedef enum logic [2:0] {
        DISARMED,
        ARMED,
        PULSE,
        GAP,
        HOLDOFF
    } glitch_state_t;

endpackage

// File: rtl/glitch_pulse_gen_sync.sv
// Two-flop synchronizer followed by an edge register. Reusable for any
// asynchronous level input; provides the synchronized level and a
// one-cycle rise strobe.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    // synchronizer chain plus the previous-level register for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;

endmodule

// File: rtl/glitch_pulse_gen.sv
// Glitch burst generator: on a synchronized rising trigger while armed,
// emits `count` pulses of `width` cycles separated by `gap` cycles.
// Optional build macro GLITCH_STATS_EN adds a saturating fire_count output.
//
// state    | meaning
// ---------+------------------------------------------------------------
// DISARMED | idle, triggers ignored, waits for arm
// ARMED    | waiting for a trigger rise
// PULSE    | glitch_out high, width timer running
// GAP      | glitch_out low between pulses, gap timer running
// HOLDOFF  | burst complete, waiting for the trigger to return low
module glitch_pulse_gen
    import glitch_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int NUM_W = DEF_NUM_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig_in,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] gap,
    input  logic [NUM_W-1:0] count,
    input  logic             rearm,
    input  logic             set_cfg,
    input  logic             arm,
    input  logic             abort,
    output logic             glitch_out,
    output logic             armed,
    output logic             busy,
    output logic             done
`ifdef GLITCH_STATS_EN
    ,
    output logic [15:0]      fire_count
`endif
);

    localparam logic [CNT_W-1:0] ONE_W = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [NUM_W-1:0] ONE_N = {{(NUM_W-1){1'b0}}, 1'b1};

    glitch_state_t state;
    glitch_state_t nxt;

    logic [CNT_W-1:0] cfg_width;
    logic [CNT_W-1:0] cfg_gap;
    logic [NUM_W-1:0] cfg_count;
    logic             cfg_rearm;
    logic [CNT_W-1:0] eff_width;
    logic [CNT_W-1:0] eff_gap;
    logic [NUM_W-1:0] eff_count;

    logic [CNT_W-1:0] tmr;
    logic [CNT_W-1:0] tmr_nxt;
    logic [NUM_W-1:0] pcnt;
    logic [NUM_W-1:0] pcnt_nxt;

    logic trig_level;
    logic trig_rise;
    logic trig_evt;
    logic burst_end;

    sync_edge_detect u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (trig_in),
        .level    (trig_level),
        .rise     (trig_rise)
    );

    // zero in any timing field is treated as one cycle / one pulse
    assign eff_width = (cfg_width == '0) ? ONE_W : cfg_width;
    assign eff_gap   = (cfg_gap   == '0) ? ONE_W : cfg_gap;
    assign eff_count = (cfg_count == '0) ? ONE_N : cfg_count;

    // configuration latch, frozen while a burst is in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_width <= '0;
            cfg_gap   <= '0;
            cfg_count <= '0;
            cfg_rearm <= 1'b0;
        end else if (set_cfg && (state == DISARMED || state == ARMED)) begin
            cfg_width <= width;
            cfg_gap   <= gap;
            cfg_count <= count;
            cfg_rearm <= rearm;
        end
    end

    // next-state, timer reloads and burst-completion detect; abort overrides all
    always_comb begin
        nxt       = state;
        tmr_nxt   = tmr;
        pcnt_nxt  = pcnt;
        burst_end = 1'b0;
        case (state)
            DISARMED: begin
                if (arm) nxt = ARMED;
            end
            ARMED: begin
                if (trig_evt) begin
                    nxt      = PULSE;
                    tmr_nxt  = eff_width;
                    pcnt_nxt = eff_count;
                end
            end
            PULSE: begin
                if (tmr == ONE_W) begin
                    if (pcnt == ONE_N) begin
                        nxt       = HOLDOFF;
                        burst_end = 1'b1;
                    end else begin
                        nxt      = GAP;
                        tmr_nxt  = eff_gap;
                        pcnt_nxt = pcnt - ONE_N;
                    end
                end else begin
                    tmr_nxt = tmr - ONE_W;
                end
            end
            GAP: begin
                if (tmr == ONE_W) begin
                    nxt     = PULSE;
                    tmr_nxt = eff_width;
                end else begin
                    tmr_nxt = tmr - ONE_W;
                end
            end
            HOLDOFF: begin
                if (!trig_level) nxt = cfg_rearm ? ARMED : DISARMED;
            end
            default: nxt = DISARMED;
        endcase
        if (abort) begin
            nxt       = DISARMED;
            burst_end = 1'b0;
        end
    end

    // state, timers and registered outputs; the trigger strobe is retimed one
    // cycle so glitch_out can be registered straight from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= DISARMED;
            tmr        <= '0;
            pcnt       <= '0;
            trig_evt   <= 1'b0;
            glitch_out <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= nxt;
            tmr        <= tmr_nxt;
            pcnt       <= pcnt_nxt;
            trig_evt   <= trig_rise;
            glitch_out <= (nxt == PULSE);
            done       <= burst_end;
        end
    end

    assign armed = (state == ARMED);
    assign busy  = (state == PULSE) || (state == GAP);

`ifdef GLITCH_STATS_EN
    // completed-burst counter, saturating, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fire_count <= '0;
        end else if (done && fire_count != 16'hFFFF) begin
            fire_count <= fire_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_glitch_pulse_gen.sv
module tb_glitch_pulse_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trig_in = 1'b0;
    logic [15:0] width = '0;
    logic [15:0] gap = '0;
    logic [7:0]  count = '0;
    logic        rearm = 1'b0;
    logic        set_cfg = 1'b0;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic        glitch_out;
    logic        armed;
    logic        busy;
    logic        done;
`ifdef GLITCH_STATS_EN
    logic [15:0] fire_count;
`endif

    glitch_pulse_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trig_in    (trig_in),
        .width      (width),
        .gap        (gap),
        .count      (count),
        .rearm      (rearm),
        .set_cfg    (set_cfg),
        .arm        (arm),
        .abort      (abort),
        .glitch_out (glitch_out),
        .armed      (armed),
        .busy       (busy),
        .done       (done)
`ifdef GLITCH_STATS_EN
        ,
        .fire_count (fire_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 0 = pulse (cyc = first high cycle, len = high cycles), 1 = done
        int cyc;
        int len;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  total = 0;
    int  bad = 0;
    int  g_start = 0;
    logic g_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic ev_check(input int kind, input int c, input int len);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got kind=%0d cyc=%0d len=%0d expected nothing", kind, c, len);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != c || e.len != len) begin
                bad++;
                $display("FAIL event: got kind=%0d cyc=%0d len=%0d expected kind=%0d cyc=%0d len=%0d",
                         kind, c, len, e.kind, e.cyc, e.len);
            end
        end
    endtask

    // monitor: reports each completed glitch pulse and each done strobe
    always @(negedge clk) begin
        if (!rst_n) begin
            g_prev = 1'b0;
        end else begin
            if (glitch_out && !g_prev) g_start = cyc;
            if (!glitch_out && g_prev) ev_check(0, g_start, cyc - g_start);
            if (done) ev_check(1, cyc, 0);
            g_prev = glitch_out;
        end
    end

    task automatic push_ev(input int kind, input int c, input int len);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.len  = len;
        exp_q.push_back(e);
    endtask

    // t = posedge that first samples trig_in high; first pulse high from t+3
    task automatic expect_burst(input int t, input int w, input int g, input int c);
        for (int i = 0; i < c; i++) push_ev(0, t + 3 + i * (w + g), w);
        push_ev(1, t + 3 + c * w + (c - 1) * g, 0);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg(input int w, input int g, input int c, input bit r);
        @(negedge clk);
        width = 16'(w); gap = 16'(g); count = 8'(c); rearm = r; set_cfg = 1'b1;
        @(negedge clk);
        set_cfg = 1'b0;
    endtask

    task automatic do_arm;
        @(negedge clk); arm = 1'b1;
        @(negedge clk); arm = 1'b0;
    endtask

    task automatic trig_up(output int t);
        @(negedge clk);
        trig_in = 1'b1;
        t = cyc + 1;
    endtask

    task automatic trig_down;
        @(negedge clk); trig_in = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout: got %0d pending events expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // arm from DISARMED, fire one trigger and check the burst with effective values
    task automatic run_burst(input string name, input int w, input int g, input int c);
        int t;
        do_arm;
        trig_up(t);
        expect_burst(t, w, g, c);
        tick(2);
        trig_down;
        wait_drain(name);
        tick(4);
    endtask

    initial begin
        int t;
        tick(3);
        chk("rst_glitch", glitch_out, 0);
        chk("rst_armed", armed, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
`ifdef GLITCH_STATS_EN
        chk("rst_fire_count", fire_count, 0);
`endif
        rst_n = 1'b1;
        tick(2);

        // basic burst w3 g2 c2, one-shot
        cfg(3, 2, 2, 0);
        do_arm;
        chk("armed_after_arm", armed, 1);
        trig_up(t);
        expect_burst(t, 3, 2, 2);
        tick(3);
        trig_down;
        wait_drain("burst");
        tick(5);
        chk("burst_disarmed", armed, 0);
        chk("burst_idle", busy, 0);

        // zero config behaves as 1/1/1
        cfg(0, 0, 0, 0);
        run_burst("zero_cfg", 1, 1, 1);
        chk("zero_disarmed", armed, 0);

        // auto-rearm; trigger held high keeps the block in holdoff
        cfg(1, 0, 1, 1);
        do_arm;
        trig_up(t);
        expect_burst(t, 1, 1, 1);
        tick(15);
        chk("holdoff_not_armed", armed, 0);
        chk("holdoff_not_busy", busy, 0);
        trig_down;
        tick(4);
        chk("rearmed", armed, 1);
        trig_up(t);
        expect_burst(t, 1, 1, 1);
        tick(2);
        trig_down;
        wait_drain("rearm2");
        tick(5);
        chk("rearmed2", armed, 1);
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("abort_from_armed", armed, 0);

        // abort during second pulse of a count=4 burst
        cfg(4, 2, 4, 0);
        do_arm;
        trig_up(t);
        push_ev(0, t + 3, 4);
        push_ev(0, t + 9, 1);
        tick(2);
        trig_down;
        while (cyc < t + 9) @(negedge clk);
        chk("abort_pre_high", glitch_out, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_glitch", glitch_out, 0);
        chk("abort_armed", armed, 0);
        chk("abort_busy", busy, 0);
        wait_drain("abort");
        tick(20);

        // arm and abort together: abort wins, later trigger ignored
        @(negedge clk); arm = 1'b1; abort = 1'b1;
        @(negedge clk); arm = 1'b0; abort = 1'b0;
        chk("arm_abort_armed", armed, 0);
        trig_up(t);
        tick(2);
        trig_down;
        tick(10);
        chk("disarmed_trig_busy", busy, 0);

        // set_cfg mid-burst is ignored for this and the next burst
        cfg(2, 1, 3, 0);
        do_arm;
        trig_up(t);
        expect_burst(t, 2, 1, 3);
        tick(2);
        trig_down;
        while (cyc < t + 6) @(negedge clk);
        cfg(9, 1, 1, 0);
        wait_drain("cfg_busy1");
        tick(4);
        chk("cfg_busy_disarmed", armed, 0);
        run_burst("cfg_busy2", 2, 1, 3);

        // asynchronous reset mid-pulse
        cfg(5, 1, 1, 0);
        do_arm;
        trig_up(t);
        tick(2);
        trig_down;
        while (cyc < t + 4) @(negedge clk);
        chk("pre_reset_high", glitch_out, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_glitch", glitch_out, 0);
        chk("async_rst_busy", busy, 0);
        tick(3);
        chk("async_rst_done", done, 0);
        rst_n = 1'b1;
        tick(5);
        chk("post_rst_armed", armed, 0);
        // config registers cleared by reset: behaves as 1/1/1
        run_burst("post_rst_cfg", 1, 1, 1);

`ifdef GLITCH_STATS_EN
        run_burst("stats2", 1, 1, 1);
        run_burst("stats3", 1, 1, 1);
        chk("fire_count_3", fire_count, 3);
        @(negedge clk);
        force dut.fire_count = 16'hFFFF;
        @(negedge clk);
        release dut.fire_count;
        run_burst("stats_sat", 1, 1, 1);
        chk("fire_count_sat", fire_count, 16'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1);
    end

endmodule
